// File: rtl/call_return_ctrl.sv
// CALL/RET sequencer for the flag+data LIFO stack: issues push/pop strobes,
// tracks depth, flags overflow/underflow and hands the restored PC/flags back.
module call_return_ctrl #(
    parameter int DATA_W  = 8,
    parameter int FLAG_W  = 4,
    parameter int DEPTH   = 16,
    parameter int DEPTH_W = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               call_req,
    input  logic               ret_req,
    input  logic [DATA_W-1:0]  pc,
    input  logic [DATA_W-1:0]  target_addr,
    input  logic [FLAG_W-1:0]  flags_in,
    input  logic [DATA_W-1:0]  stk_data_in,
    input  logic [FLAG_W-1:0]  stk_flag_in,
    output logic               stk_push,
    output logic               stk_pop,
    output logic               stk_drive,
    output logic [DATA_W-1:0]  stk_data_out,
    output logic [FLAG_W-1:0]  stk_flag_out,
    output logic               pc_load,
    output logic [DATA_W-1:0]  pc_next,
    output logic               flags_load,
    output logic [FLAG_W-1:0]  flags_next,
    output logic               busy,
    output logic [DEPTH_W-1:0] depth,
    output logic               ovf_err,
    output logic               unf_err
);

    typedef enum logic [2:0] {IDLE, PUSH, JUMP, POP, RESTORE} state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   ret_addr, target, rest_pc;
    logic [FLAG_W-1:0]   saved_flags, rest_flags;
    logic                accept_call, ovf_set, unf_set;
    logic                full, empty;

    assign full  = (depth == DEPTH_W'(DEPTH));
    assign empty = (depth == '0);

    // NOTE: every output and helper gets a default first so no path leaves a latch.
    always_comb begin
        state_nxt    = state;
        accept_call  = 1'b0;
        ovf_set      = 1'b0;
        unf_set      = 1'b0;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        stk_drive    = 1'b0;
        stk_data_out = '0;
        stk_flag_out = '0;
        pc_load      = 1'b0;
        pc_next      = '0;
        flags_load   = 1'b0;
        flags_next   = '0;
        busy         = (state != IDLE);
        unique case (state)
            IDLE: begin
                // CALL has priority; a simultaneous RET is dropped.
                if (call_req) begin
                    if (full) ovf_set = 1'b1;
                    else begin
                        accept_call = 1'b1;
                        state_nxt   = PUSH;
                    end
                end else if (ret_req) begin
                    if (empty) unf_set = 1'b1;
                    else       state_nxt = POP;
                end
            end
            PUSH: begin
                stk_push     = 1'b1;
                stk_drive    = 1'b1;
                stk_data_out = ret_addr;
                stk_flag_out = saved_flags;
                state_nxt    = JUMP;
            end
            JUMP: begin
                pc_load   = 1'b1;
                pc_next   = target;
                state_nxt = IDLE;
            end
            POP: begin
                stk_pop   = 1'b1;
                state_nxt = RESTORE;
            end
            RESTORE: begin
                pc_load    = 1'b1;
                flags_load = 1'b1;
                pc_next    = rest_pc;
                flags_next = rest_flags;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            depth   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            ovf_err <= ovf_err | ovf_set;
            unf_err <= unf_err | unf_set;
            if (state == PUSH)     depth <= depth + DEPTH_W'(1);
            else if (state == POP) depth <= depth - DEPTH_W'(1);
        end
    end

    // NOTE: the capture registers are reset too, so no stale value can reach the data outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ret_addr    <= '0;
            target      <= '0;
            saved_flags <= '0;
            rest_pc     <= '0;
            rest_flags  <= '0;
        end else begin
            if (accept_call) begin
                ret_addr    <= pc + DATA_W'(1);
                target      <= target_addr;
                saved_flags <= flags_in;
            end
            if (state == POP) begin
                rest_pc    <= stk_data_in;
                rest_flags <= stk_flag_in;
            end
        end
    end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Scoreboard bench for call_return_ctrl: a model stack predicts every cycle's
// strobes/data; expected cycles are queued at request time and popped per clock.
module tb_call_return_ctrl;

    logic       CLK, RESET;
    logic       call_req, ret_req;
    logic [7:0] pc, target_addr, stk_data_in;
    logic [3:0] flags_in, stk_flag_in;
    logic       stk_push, stk_pop, stk_drive, pc_load, flags_load, busy, ovf_err, unf_err;
    logic [7:0] stk_data_out, pc_next;
    logic [3:0] stk_flag_out, flags_next;
    logic [4:0] depth;

    call_return_ctrl #(.DATA_W(8), .FLAG_W(4), .DEPTH(16), .DEPTH_W(5)) dut (
        .CLK(CLK), .RESET(RESET), .call_req(call_req), .ret_req(ret_req),
        .pc(pc), .target_addr(target_addr), .flags_in(flags_in),
        .stk_data_in(stk_data_in), .stk_flag_in(stk_flag_in),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_drive(stk_drive),
        .stk_data_out(stk_data_out), .stk_flag_out(stk_flag_out),
        .pc_load(pc_load), .pc_next(pc_next), .flags_load(flags_load),
        .flags_next(flags_next), .busy(busy), .depth(depth),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    typedef struct packed {
        logic       push, pop, drive;
        logic [7:0] data_out;
        logic [3:0] flag_out;
        logic       pc_load;
        logic [7:0] pc_next;
        logic       flags_load;
        logic [3:0] flags_next;
        logic       busy;
    } obs_t;

    obs_t       sb[$];
    logic [7:0] mstack_d[16];
    logic [3:0] mstack_f[16];
    int         mdepth;
    logic       movf, munf;
    int         total, bad;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk_push(input logic [7:0] d, input logic [3:0] f);
        obs_t o = '0;
        o.push = 1'b1; o.drive = 1'b1; o.data_out = d; o.flag_out = f; o.busy = 1'b1;
        return o;
    endfunction

    function automatic obs_t mk_jump(input logic [7:0] t);
        obs_t o = '0;
        o.pc_load = 1'b1; o.pc_next = t; o.busy = 1'b1;
        return o;
    endfunction

    function automatic obs_t mk_pop();
        obs_t o = '0;
        o.pop = 1'b1; o.busy = 1'b1;
        return o;
    endfunction

    function automatic obs_t mk_restore(input logic [7:0] d, input logic [3:0] f);
        obs_t o = '0;
        o.pc_load = 1'b1; o.flags_load = 1'b1; o.pc_next = d; o.flags_next = f; o.busy = 1'b1;
        return o;
    endfunction

    // Advance one clock and compare the new cycle's outputs against the scoreboard head
    // (an empty scoreboard means the DUT must be idle with every strobe low).
    task automatic tick();
        obs_t act, exp_o;
        @(posedge CLK);
        #1;
        act = {stk_push, stk_pop, stk_drive, stk_data_out, stk_flag_out,
               pc_load, pc_next, flags_load, flags_next, busy};
        exp_o = (sb.size() > 0) ? sb.pop_front() : obs_t'('0);
        total++;
        if (act !== exp_o) begin
            bad++;
            $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, act, exp_o);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mdepth = 0;
        movf   = 1'b0;
        munf   = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET = 1'b1;
        #2;
        RESET = 1'b0;
        model_reset();
    endtask

    task automatic check_status(input string name);
        logic [4:0] exp_d;
        exp_d = mdepth[4:0];
        total++;
        if (depth !== exp_d || ovf_err !== movf || unf_err !== munf || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: depth=%0d ovf=%b unf=%b busy=%b expected depth=%0d ovf=%b unf=%b busy=0",
                     name, depth, ovf_err, unf_err, busy, exp_d, movf, munf);
        end
    endtask

    // Drive one request in an idle cycle and let the sequence complete (3 cycles).
    // hold keeps the request lines high through the busy cycles.
    task automatic issue(input logic c, input logic r, input logic [7:0] p, input logic [7:0] t,
                         input logic [3:0] f, input logic hold);
        logic       acc_ret;
        logic [7:0] td, ra;
        logic [3:0] tf;
        acc_ret = 1'b0;
        td = 8'h00;
        tf = 4'h0;
        ra = p + 8'd1;
        if (c) begin
            if (mdepth < 16) begin
                sb.push_back(mk_push(ra, f));
                sb.push_back(mk_jump(t));
                mstack_d[mdepth] = ra;
                mstack_f[mdepth] = f;
                mdepth++;
            end else movf = 1'b1;
        end else if (r) begin
            if (mdepth > 0) begin
                mdepth--;
                td = mstack_d[mdepth];
                tf = mstack_f[mdepth];
                sb.push_back(mk_pop());
                sb.push_back(mk_restore(td, tf));
                acc_ret = 1'b1;
            end else munf = 1'b1;
        end
        call_req = c; ret_req = r; pc = p; target_addr = t; flags_in = f;
        tick();
        if (!hold) begin call_req = 1'b0; ret_req = 1'b0; end
        pc = ~p; target_addr = ~t; flags_in = ~f;
        if (acc_ret) begin stk_data_in = td; stk_flag_in = tf; end
        tick();
        stk_data_in = td ^ 8'hFF;
        stk_flag_in = tf ^ 4'hF;
        tick();
        call_req = 1'b0; ret_req = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        #1;
        total++;
        if ({stk_push, stk_pop, stk_drive, stk_data_out, stk_flag_out, pc_load, pc_next,
             flags_load, flags_next, busy, depth, ovf_err, unf_err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: push=%b pop=%b drive=%b pc_load=%b busy=%b depth=%0d expected all zero",
                     stk_push, stk_pop, stk_drive, pc_load, busy, depth);
        end
        #11;
        RESET = 1'b0;
        model_reset();
        tick();
        check_status("reset_idle");
    endtask

    task automatic test_call_basic();
        issue(1'b1, 1'b0, 8'h10, 8'h40, 4'hA, 1'b0);
        check_status("call_basic");
    endtask

    task automatic test_call_ret();
        issue(1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        check_status("ret_after_call");
        issue(1'b1, 1'b0, 8'h33, 8'h90, 4'h6, 1'b0);
        issue(1'b1, 1'b0, 8'h7C, 8'h21, 4'h9, 1'b0);
        issue(1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        issue(1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        check_status("nested_call_ret");
    endtask

    task automatic test_overflow_underflow();
        apply_reset();
        for (int i = 0; i < 16; i++)
            issue(1'b1, 1'b0, 8'(i * 13 + 2), 8'(i * 7 + 100), 4'(i), 1'b0);
        check_status("fill_16");
        issue(1'b1, 1'b0, 8'h55, 8'h66, 4'h7, 1'b0);
        check_status("overflow");
        for (int i = 0; i < 16; i++)
            issue(1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        check_status("drain_16");
        issue(1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 1'b0);
        check_status("underflow_sticky");
    endtask

    task automatic test_both_req();
        apply_reset();
        for (int i = 0; i < 3; i++)
            issue(1'b1, 1'b0, 8'(i + 8'h20), 8'(i + 8'hC0), 4'(i + 1), 1'b0);
        issue(1'b1, 1'b1, 8'h44, 8'hE0, 4'hC, 1'b0);
        check_status("both_req_call_wins");
    endtask

    task automatic test_wrap_busy();
        issue(1'b1, 1'b0, 8'hFF, 8'h80, 4'h5, 1'b1);
        check_status("wrap_and_busy_ignore");
        issue(1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 1'b1);
        check_status("ret_busy_ignore");
    endtask

    task automatic test_async_reset();
        apply_reset();
        sb.push_back(mk_push(8'h31, 4'h3));
        call_req = 1'b1; pc = 8'h30; target_addr = 8'h70; flags_in = 4'h3;
        tick();
        call_req = 1'b0;
        #1;
        RESET = 1'b1;
        #1;
        total++;
        if ({stk_push, stk_pop, stk_drive, stk_data_out, stk_flag_out, pc_load, pc_next,
             flags_load, flags_next, busy, depth} !== '0) begin
            bad++;
            $display("FAIL async_reset_mid_push: push=%b drive=%b data=%h busy=%b depth=%0d expected all zero",
                     stk_push, stk_drive, stk_data_out, busy, depth);
        end
        #1;
        RESET = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) tick();
        check_status("after_async_reset");
    endtask

    initial begin
        total = 0; bad = 0;
        call_req = 1'b0; ret_req = 1'b0;
        pc = 8'h00; target_addr = 8'h00; flags_in = 4'h0;
        stk_data_in = 8'hA5; stk_flag_in = 4'h5;
        model_reset();
        test_reset();
        test_call_basic();
        test_call_ret();
        test_overflow_underflow();
        test_both_req();
        test_wrap_busy();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
